// File: rtl/fpu_operand_loader_if.sv
// Bus bundle between the FPU operand loader and its environment:
// byte stream in, operand/result lines to and from the FPU adder,
// captured result out, plus the abort and checksum-error sideband.
// slave  : loader view.  master : environment (sequencer/FPU/consumer) view.
interface fpu_operand_loader_if;
   logic        abort;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] op_A_out;
   logic [31:0] op_B_out;
   logic [31:0] result_in;
   logic [3:0]  status_in;
   logic [31:0] result_out;
   logic [3:0]  status_q;
   logic        status_err;
   logic        result_valid;
   logic        result_ack;
   logic        chk_err;

   modport slave (
      input  abort, byte_in, byte_valid, result_in, status_in, result_ack,
      output byte_ready, op_A_out, op_B_out, result_out, status_q,
             status_err, result_valid, chk_err
   );

   modport master (
      output abort, byte_in, byte_valid, result_in, status_in, result_ack,
      input  byte_ready, op_A_out, op_B_out, result_out, status_q,
             status_err, result_valid, chk_err
   );
endinterface

// File: rtl/fpu_operand_loader.sv
// FPU operand loader: assembles two big-endian 32-bit operands from a byte
// stream, commits both to the FPU together, holds them for HOLD_CYCLES so the
// free-running FPU completes a full pass, then captures and presents the
// result/status with a valid/ack handshake.
// Optional macro FPU_OPERAND_LOADER_CHECKSUM_EN: a 9th byte carrying the XOR
// of the eight operand bytes is required; a mismatch drops the load and
// pulses chk_err.
module fpu_operand_loader #(
   parameter int unsigned HOLD_CYCLES = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic                   clock100KHz,
   input  logic                   reset,
   fpu_operand_loader_if.slave    lb
);

`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
   localparam int unsigned NUM_BYTES = 9;
`else
   localparam int unsigned NUM_BYTES = 8;
`endif
   // Shadow holds every byte before the final one of a load.
   localparam int unsigned SH_W     = (NUM_BYTES - 1) * 8;
   localparam logic [3:0]  LAST_IDX = 4'(NUM_BYTES - 1);

   typedef enum logic [1:0] {LOAD, HOLD, CAPTURE, PRESENT} state_t;

   state_t             state_q, state_d;
   logic [3:0]         byte_cnt_q;
   logic [CNT_W-1:0]   hold_cnt_q;
   logic [SH_W-1:0]    shadow_q;
   logic [31:0]        op_a_q, op_b_q;
   logic [31:0]        result_q;
   logic [3:0]         status_r;
   logic               status_err_q;
   logic               result_valid_q;
   logic               take;
   logic               commit;
   logic               chk_bad;
   logic               hold_done;
   logic [63:0]        operand_word;

`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
   logic [7:0]         xor_q;
   logic               chk_err_q;
   assign operand_word = shadow_q;
`else
   assign operand_word = {shadow_q, lb.byte_in};
`endif

   assign hold_done = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));

   // State register.
   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) state_q <= LOAD;
      else        state_q <= state_d;
   end

   // Next-state and per-cycle load decisions; abort overrides everything.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      commit  = 1'b0;
      chk_bad = 1'b0;
      unique case (state_q)
         LOAD: begin
            if (lb.byte_valid) begin
               take = 1'b1;
               if (byte_cnt_q == LAST_IDX) begin
`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
                  if (lb.byte_in == xor_q) commit  = 1'b1;
                  else                     chk_bad = 1'b1;
`else
                  commit = 1'b1;
`endif
               end
            end
         end
         HOLD:    if (hold_done) state_d = CAPTURE;
         CAPTURE: state_d = PRESENT;
         PRESENT: if (lb.result_ack) state_d = LOAD;
         default: state_d = LOAD;
      endcase
      if (commit) state_d = HOLD;
      if (lb.abort) begin
         state_d = LOAD;
         take    = 1'b0;
         commit  = 1'b0;
         chk_bad = 1'b0;
      end
   end

   // Byte assembly, operand commit and hold counter.
   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         byte_cnt_q <= '0;
         hold_cnt_q <= '0;
         shadow_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else if (lb.abort) begin
         byte_cnt_q <= '0;
         hold_cnt_q <= '0;
`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         if (take) begin
            shadow_q <= {shadow_q[SH_W-9:0], lb.byte_in};
            if (commit || chk_bad) begin
               byte_cnt_q <= '0;
`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
               xor_q      <= '0;
`endif
            end else begin
               byte_cnt_q <= byte_cnt_q + 4'd1;
`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
               xor_q      <= xor_q ^ lb.byte_in;
`endif
            end
         end
         if (commit) begin
            op_a_q     <= operand_word[63:32];
            op_b_q     <= operand_word[31:0];
            hold_cnt_q <= '0;
         end else if (state_q == HOLD) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
         end
         if (state_q == PRESENT && lb.result_ack) byte_cnt_q <= '0;
      end
   end

   // Result capture and valid/ack handshake.
   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         result_q       <= '0;
         status_r       <= '0;
         status_err_q   <= 1'b0;
         result_valid_q <= 1'b0;
      end else if (lb.abort) begin
         result_valid_q <= 1'b0;
      end else if (state_q == CAPTURE) begin
         result_q       <= lb.result_in;
         status_r       <= lb.status_in;
         status_err_q   <= !$onehot(lb.status_in);
         result_valid_q <= 1'b1;
      end else if (state_q == PRESENT && lb.result_ack) begin
         result_valid_q <= 1'b0;
      end
   end

`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
   // One-cycle checksum mismatch pulse.
   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) chk_err_q <= 1'b0;
      else        chk_err_q <= chk_bad;
   end
   assign lb.chk_err = chk_err_q;
`else
   assign lb.chk_err = 1'b0;
`endif

   assign lb.byte_ready   = (state_q == LOAD);
   assign lb.op_A_out     = op_a_q;
   assign lb.op_B_out     = op_b_q;
   assign lb.result_out   = result_q;
   assign lb.status_q     = status_r;
   assign lb.status_err   = status_err_q;
   assign lb.result_valid = result_valid_q;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Bench for fpu_operand_loader: table of operand loads with stub FPU
// result/status, scoreboard of expected captures, and hand-written abort,
// reset and checksum sequences.
module tb_fpu_operand_loader;
   localparam int unsigned HOLD = 64;
`ifdef FPU_OPERAND_LOADER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic clock100KHz = 1'b0;
   logic reset       = 1'b0;
   always #5 clock100KHz = ~clock100KHz;

   fpu_operand_loader_if bus ();

   fpu_operand_loader #(.HOLD_CYCLES(HOLD), .CNT_W(7)) dut (
      .clock100KHz (clock100KHz),
      .reset       (reset),
      .lb          (bus)
   );

   typedef struct {
      logic [63:0] stream;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] res;
      logic [3:0]  st;
      logic        exp_err;
      bit          gap;
      int unsigned ack_delay;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  st;
      logic        err;
   } exp_t;

   vec_t        vecs [4];
   exp_t        sb [$];
   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [31:0] last_a   = '0;
   logic [31:0] last_b   = '0;
   logic        rv_prev  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: compare each newly presented result against the oldest expectation.
   always @(negedge clock100KHz) begin
      if (bus.result_valid && !rv_prev) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 64'(bus.result_valid), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_out", 64'(bus.result_out), 64'(e.res));
            check("status_q",   64'(bus.status_q),   64'(e.st));
            check("status_err", 64'(bus.status_err), 64'(e.err));
         end
      end
      rv_prev = bus.result_valid;
   end

   // Called at a negedge; offers one byte and returns at the next negedge.
   task automatic send_byte(input logic [7:0] v, input bit gap);
      bus.byte_in    = v;
      bus.byte_valid = 1'b1;
      @(negedge clock100KHz);
      bus.byte_valid = 1'b0;
      if (gap) @(negedge clock100KHz);
   endtask

   task automatic load_vec(input vec_t v, input bit push, input bit bad_ck);
      logic [7:0] b;
      logic [7:0] ck;
      bus.result_in = v.res;
      bus.status_in = v.st;
      if (push) sb.push_back('{res: v.res, st: v.st, err: v.exp_err});
      ck = '0;
      for (int i = 0; i < 8; i++) begin
         b  = v.stream[63-8*i -: 8];
         ck = ck ^ b;
         send_byte(b, v.gap && (i != 7 || CK_EN));
      end
      if (CK_EN) send_byte(bad_ck ? (ck ^ 8'h01) : ck, 1'b0);
      if (CK_EN && bad_ck) begin
         check("ops_kept_on_bad_ck", {bus.op_A_out, bus.op_B_out}, {last_a, last_b});
      end else begin
         check("ops_commit", {bus.op_A_out, bus.op_B_out}, {v.exp_a, v.exp_b});
         check("ready_in_hold", 64'(bus.byte_ready), 64'(0));
         last_a = v.exp_a;
         last_b = v.exp_b;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned k;
      load_vec(v, 1'b1, 1'b0);
      k = 0;
      while (!bus.result_valid && k < 200) begin
         @(negedge clock100KHz);
         k++;
      end
      check("capture_latency", 64'(k), 64'(HOLD + 1));
      bus.result_in = ~v.res;
      bus.status_in = ~v.st;
      for (int unsigned c = 0; c < v.ack_delay; c++) begin
         check("present_hold", {27'b0, bus.result_valid, bus.byte_ready, bus.result_out, bus.status_q},
               {27'b0, 1'b1, 1'b0, v.res, v.st});
         @(negedge clock100KHz);
      end
      bus.result_ack = 1'b1;
      @(negedge clock100KHz);
      bus.result_ack = 1'b0;
      check("after_ack", {62'b0, bus.result_valid, bus.byte_ready}, {62'b0, 1'b0, 1'b1});
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_ops"}, {bus.op_A_out, bus.op_B_out}, 64'(0));
      check({name, "_outs"},
            {24'b0, bus.result_out, bus.status_q, bus.status_err, bus.result_valid, bus.chk_err, bus.byte_ready},
            {24'b0, 32'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1});
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_rv;
      vecs[0] = '{64'h40000000_40000000, 32'h40000000, 32'h40000000, 32'h41000000, 4'b0001, 1'b0, 1'b0, 0};
      vecs[1] = '{64'h3F801234_C000ABCD, 32'h3F801234, 32'hC000ABCD, 32'h12345678, 4'b0010, 1'b0, 1'b1, 10};
      vecs[2] = '{64'h01020304_05060708, 32'h01020304, 32'h05060708, 32'hDEADBEEF, 4'b0110, 1'b1, 1'b0, 0};
      vecs[3] = '{64'hFF00FF00_80000001, 32'hFF00FF00, 32'h80000001, 32'h00000000, 4'b0000, 1'b1, 1'b1, 2};

      bus.abort      = 1'b0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      bus.result_in  = '0;
      bus.status_in  = '0;
      bus.result_ack = 1'b0;

      repeat (3) @(negedge clock100KHz);
      check_reset_state("reset");
      reset = 1'b1;
      @(negedge clock100KHz);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Abort after five bytes; the byte offered alongside abort must be dropped.
      for (int i = 0; i < 5; i++) send_byte(vecs[0].stream[63-8*i -: 8], 1'b0);
      bus.abort      = 1'b1;
      bus.byte_in    = 8'hAA;
      bus.byte_valid = 1'b1;
      @(negedge clock100KHz);
      bus.abort      = 1'b0;
      bus.byte_valid = 1'b0;
      check("abort_load_ops", {bus.op_A_out, bus.op_B_out}, {last_a, last_b});
      check("abort_load_ready", 64'(bus.byte_ready), 64'(1));
      run_vec(vecs[1]);

      if (CK_EN) begin
         load_vec(vecs[2], 1'b0, 1'b1);
         check("chk_err_pulse", {62'b0, bus.chk_err, bus.byte_ready}, {62'b0, 1'b1, 1'b1});
         @(negedge clock100KHz);
         check("chk_err_clear", 64'(bus.chk_err), 64'(0));
         run_vec(vecs[2]);
      end else begin
         check("chk_err_tied", 64'(bus.chk_err), 64'(0));
      end

      // Abort during HOLD: no result may appear.
      load_vec(vecs[3], 1'b0, 1'b0);
      repeat (20) @(negedge clock100KHz);
      bus.abort = 1'b1;
      @(negedge clock100KHz);
      bus.abort = 1'b0;
      saw_rv = 1'b0;
      repeat (100) begin
         if (bus.result_valid) saw_rv = 1'b1;
         @(negedge clock100KHz);
      end
      check("abort_hold_no_valid", 64'(saw_rv), 64'(0));
      check("abort_hold_ready", 64'(bus.byte_ready), 64'(1));
      check("abort_hold_ops", {bus.op_A_out, bus.op_B_out}, {vecs[3].exp_a, vecs[3].exp_b});

      // Asynchronous reset while holding operands.
      load_vec(vecs[1], 1'b0, 1'b0);
      repeat (10) @(negedge clock100KHz);
      #2 reset = 1'b0;
      #1 check_reset_state("reset_mid");
      @(negedge clock100KHz);
      reset  = 1'b1;
      last_a = '0;
      last_b = '0;
      @(negedge clock100KHz);
      run_vec(vecs[0]);

      repeat (2) @(negedge clock100KHz);
      check("scoreboard_drained", 64'(sb.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fpu_operand_loader.md
Name: fpu_operand_loader

Overview:
- Upstream sequencer for the FPU adder. It assembles two 32-bit operands from an 8-bit byte stream using a valid/ready handshake, then commits both to the FPU operand inputs in the same cycle.
- It holds the operands stable long enough for the free-running FPU to finish, then captures the FPU result and status.
- The captured result is presented to the consumer with a valid/ack handshake.
- Operand format is unchanged: sign[31], exponent[30:25], mantissa[24:0].

Parameters:
- HOLD_CYCLES, 64: cycles operands are held before capture. Must be ≥ 2× worst-case FPU pass (about 31 cycles), because the FPU may be mid-pass when operands change.
- CNT_W, 7: width of the hold counter. Must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clock100KHz  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- abort  in  1  synchronous flush; drops partial load or pending result
- byte_in  in  8  operand byte stream
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader accepts a byte this cycle
- op_A_out  out  32  to FPU op_A_in
- op_B_out  out  32  to FPU op_B_in
- result_in  in  32  from FPU data_out
- status_in  in  4  from FPU status_out
- result_out  out  32  captured result
- status_q  out  4  captured status
- status_err  out  1  captured status_in was not exactly one-hot
- result_valid  out  1  result_out/status_q valid
- result_ack  in  1  consumer accepts result
- chk_err  out  1  one-cycle pulse on checksum mismatch (macro only; tied 0 otherwise)

Behaviour:
- Reset is asynchronous and active-low on `reset`, single clock `clock100KHz`. On reset:
  - state = LOAD
  - byte count = 0; hold counter = 0
  - all outputs = 0, except byte_ready = 1
- States: LOAD, HOLD, CAPTURE, PRESENT.
- LOAD:
  - byte_ready = 1.
  - A transfer occurs when byte_valid && byte_ready.
  - Bytes are big-endian. Bytes 0-3 form A[31:24]..A[7:0]; bytes 4-7 form B[31:24]..B[7:0]. They are assembled in a shadow register.
  - op_A_out and op_B_out keep their old values until the 8th byte is accepted. In the following cycle both update together, the hold counter clears, and state → HOLD.
  - byte_valid low: count holds, no change.
- HOLD:
  - byte_ready = 0.
  - The counter increments each cycle. When it equals HOLD_CYCLES-1, state → CAPTURE.
  - Operands are stable throughout.
- CAPTURE (one cycle):
  - result_out ← result_in; status_q ← status_in.
  - status_err ← (status_in not one-hot).
  - result_valid ← 1; state → PRESENT.
- Capture latency: result_valid rises HOLD_CYCLES+1 cycles after the operand commit edge.
- PRESENT:
  - result_valid is held at 1 and result_out/status_q are held stable until result_ack.
  - On result_valid && result_ack: result_valid ← 0, byte count ← 0, state → LOAD. byte_ready is 1 in the next cycle.
  - result_ack while result_valid = 0 is ignored.
- op_A_out/op_B_out retain their last committed values after a result is acknowledged. They change only on the next full 8-byte commit.
- abort (any state, has priority over all other events in that cycle):
  - byte count ← 0; hold counter ← 0; result_valid ← 0; state → LOAD.
  - op_A_out, op_B_out, result_out and status_q retain their values.
  - A byte offered in the same cycle as abort is not accepted.
- Reset mid-operation: immediate return to reset values; no partial commit.
- Byte count wraps 7 → 0 only through the commit path, never silently.

Optional Feature:
- Macro: FPU_OPERAND_LOADER_CHECKSUM_EN.
- With the macro defined:
  - LOAD expects 9 bytes. The 9th byte must equal the XOR of bytes 0-7.
  - Match: commit as above.
  - Mismatch: no commit; chk_err pulses for 1 cycle; byte count ← 0; state stays LOAD.
- Without the macro: 8-byte load, no checksum, and chk_err is tied 0.

Test Plan:
- Basic load and capture:
  - Stimulus: bytes 40 00 00 00 40 00 00 00 (checksum 00 when macro on); stub drives result_in = 0x41000000, status_in = 0001.
  - Required: op_A_out = op_B_out = 0x40000000 one cycle after the last byte.
  - Required: result_valid rises 65 cycles after commit with result_out = 0x41000000, status_q = 0001, status_err = 0.
- Backpressure:
  - Stimulus: byte_valid toggled every other cycle during load; result_ack held 0 for 10 cycles.
  - Required: operands are assembled correctly.
  - Required: result_valid stays 1 with stable data for those 10 cycles; byte_ready = 0 until the ack cycle+1.
- Abort:
  - Stimulus: abort after byte 5.
  - Required: previous operands are unchanged; a following full 8-byte load commits the new values.
  - Stimulus: abort during HOLD.
  - Required: no result_valid is produced.
- Bad status:
  - Stimulus: status_in = 0110 at capture.
  - Required: status_err = 1, status_q = 0110.
- Reset mid-operation:
  - Stimulus: reset asserted during HOLD.
  - Required: all outputs immediately 0, byte_ready = 1 immediately, state = LOAD.
- Checksum (macro on):
  - Stimulus: 9th byte wrong (e.g. 0x01 instead of 0x00).
  - Required: chk_err single-cycle pulse; operands unchanged; next correct 9-byte load commits.
